// File: rtl/ctrl_pkg.sv
//==============================================================================
// Module  : ctrl_pkg
// Brief   : Shared opcodes, input-mux codes, field positions and FSM encoding
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package ctrl_pkg;

  localparam logic [1:0] OP_MOV = 2'b00;
  localparam logic [1:0] OP_LDI = 2'b01;
  localparam logic [1:0] OP_ALU = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  localparam logic [1:0] MUX_FILE = 2'b00;
  localparam logic [1:0] MUX_IMM  = 2'b01;
  localparam logic [1:0] MUX_ALU  = 2'b10;

  // Read address 3 selects the file's constant source, and is not a writable register
  localparam logic [1:0] ADDR_CONST = 2'd3;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 14;
  localparam int DST_MSB = 13;
  localparam int DST_LSB = 12;
  localparam int SRC_MSB = 11;
  localparam int SRC_LSB = 10;
  localparam int FN_MSB  = 9;
  localparam int FN_LSB  = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_EX   = 3'd3,
    ST_WB   = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/reg_file_ctrl_if.sv
//==============================================================================
// Module  : reg_file_ctrl_if
// Brief   : Instruction handshake and register-file/ALU control bundle
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

interface reg_file_ctrl_if;
  logic [15:0] INSTR;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic [2:0]  SEL;
  logic [1:0]  ADDR;
  logic [1:0]  IN_MUX;
  logic [7:0]  IMM_OUT;
  logic [1:0]  ALU_FN;
  logic        LD_A;
  logic        LD_B;
  logic        BUSY;
  logic        DONE;
  logic        ERR;

  modport master (
    output INSTR, INSTR_VALID,
    input  INSTR_READY, SEL, ADDR, IN_MUX, IMM_OUT, ALU_FN,
    input  LD_A, LD_B, BUSY, DONE, ERR
  );

  modport slave (
    input  INSTR, INSTR_VALID,
    output INSTR_READY, SEL, ADDR, IN_MUX, IMM_OUT, ALU_FN,
    output LD_A, LD_B, BUSY, DONE, ERR
  );
endinterface

`default_nettype wire

// File: rtl/sel_dec.sv
//==============================================================================
// Module  : sel_dec
// Brief   : Enabled 2-bit to one-hot register write select; code 3 gives none
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module sel_dec (
  input  wire logic       i_en,
  input  wire logic [1:0] i_code,
  output logic      [2:0] o_sel
);

  always_comb begin
    o_sel = 3'b000;
    if (i_en) begin
      case (i_code)
        2'd0:    o_sel = 3'b001;
        2'd1:    o_sel = 3'b010;
        2'd2:    o_sel = 3'b100;
        default: o_sel = 3'b000;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_file_ctrl.sv
//==============================================================================
// Module  : reg_file_ctrl
// Brief   : Micro-instruction sequencer for the 3-register file and ALU latches
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module reg_file_ctrl
  import ctrl_pkg::*;
(
  input wire logic      CLK,
  input wire logic      RST,
  reg_file_ctrl_if.slave bus
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_op;
  logic [1:0] r_dst;
  logic [1:0] r_src;
  logic [1:0] r_fn;
  logic [7:0] r_imm;
  logic [1:0] r_addr;
  logic [1:0] w_addr_nxt;
  logic       r_live;
  logic       w_ready;
  logic       w_accept;
  logic [1:0] w_in_op;
  logic [1:0] w_in_dst;
  logic [1:0] w_in_src;

  assign w_in_op  = bus.INSTR[OP_MSB:OP_LSB];
  assign w_in_dst = bus.INSTR[DST_MSB:DST_LSB];
  assign w_in_src = bus.INSTR[SRC_MSB:SRC_LSB];

  // r_live keeps READY low until the first edge after reset is released
  assign w_ready  = (r_state == ST_IDLE) && r_live;
  assign w_accept = bus.INSTR_VALID && w_ready;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_live  <= 1'b0;
      r_addr  <= 2'd0;
      r_op    <= 2'd0;
      r_dst   <= 2'd0;
      r_src   <= 2'd0;
      r_fn    <= 2'd0;
      r_imm   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_live  <= 1'b1;
      r_addr  <= w_addr_nxt;
      if (w_accept) begin
        r_op  <= w_in_op;
        r_dst <= w_in_dst;
        r_src <= w_in_src;
        r_fn  <= bus.INSTR[FN_MSB:FN_LSB];
        r_imm <= bus.INSTR[IMM_MSB:IMM_LSB];
      end
    end
  end

  // The read address is registered and only moves on entry to RD_A/RD_B,
  // so it stays put through EX and WB while the file is being written.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_in_dst == ADDR_CONST) begin
            w_state_nxt = ST_ERR;
          end else begin
            case (w_in_op)
              OP_LDI: w_state_nxt = ST_WB;
              OP_ALU: begin
                w_state_nxt = ST_RD_A;
                w_addr_nxt  = w_in_dst;
              end
              OP_CLR: begin
                w_state_nxt = ST_RD_B;
                w_addr_nxt  = ADDR_CONST;
              end
              default: begin
                w_state_nxt = ST_RD_B;
                w_addr_nxt  = w_in_src;
              end
            endcase
          end
        end
      end
      ST_RD_A: begin
        w_state_nxt = ST_RD_B;
        w_addr_nxt  = r_src;
      end
      ST_RD_B: w_state_nxt = (r_op == OP_ALU) ? ST_EX : ST_WB;
      ST_EX:   w_state_nxt = ST_WB;
      ST_WB:   w_state_nxt = ST_IDLE;
      ST_ERR:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.IN_MUX = MUX_FILE;
    if (r_state == ST_WB) begin
      case (r_op)
        OP_LDI:  bus.IN_MUX = MUX_IMM;
        OP_ALU:  bus.IN_MUX = MUX_ALU;
        default: bus.IN_MUX = MUX_FILE;
      endcase
    end
  end

  sel_dec u_sel_dec (
    .i_en   (r_state == ST_WB),
    .i_code (r_dst),
    .o_sel  (bus.SEL)
  );

  assign bus.INSTR_READY = w_ready;
  assign bus.BUSY        = (r_state != ST_IDLE);
  assign bus.ADDR        = r_addr;
  assign bus.IMM_OUT     = r_imm;
  assign bus.ALU_FN      = r_fn;
  assign bus.LD_A        = (r_state == ST_RD_B) && (r_op == OP_ALU);
  assign bus.LD_B        = (r_state == ST_EX);
  assign bus.DONE        = (r_state == ST_WB);
  assign bus.ERR         = (r_state == ST_ERR);

endmodule

`default_nettype wire

// File: tb/tb_reg_file_ctrl.sv
//==============================================================================
// Module  : tb_reg_file_ctrl
// Brief   : Self-checking bench with a register-file/ALU datapath around the DUT
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_reg_file_ctrl;
  import ctrl_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   total = 0;
  int   bad   = 0;

  reg_file_ctrl_if bus ();

  reg_file_ctrl dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] alu_f(input logic [1:0] fn, input logic [7:0] a, input logic [7:0] b);
    case (fn)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  // Surrounding datapath: registered-read file, operand latches, write mux
  logic [7:0] rf0, rf1, rf2, rf_out, op_a, op_b, wdata;

  function automatic logic [7:0] rd(input logic [1:0] a);
    case (a)
      2'd0:    return rf0;
      2'd1:    return rf1;
      2'd2:    return rf2;
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    wdata = rf_out;
    if (bus.IN_MUX == 2'b01) wdata = bus.IMM_OUT;
    else if (bus.IN_MUX == 2'b10) wdata = alu_f(bus.ALU_FN, op_a, op_b);
  end

  always @(posedge CLK) begin
    if (bus.SEL[0]) rf0 <= wdata;
    if (bus.SEL[1]) rf1 <= wdata;
    if (bus.SEL[2]) rf2 <= wdata;
    rf_out <= rd(bus.ADDR);
    if (bus.LD_A) op_a <= rf_out;
    if (bus.LD_B) op_b <= rf_out;
  end

  // Architectural reference: register contents after each completed instruction
  logic [7:0] mr [3];
  bit         mv [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_apply(input logic [15:0] ins);
    logic [1:0] op, d, s;
    logic [7:0] sv;
    bit         svalid;
    op = ins[15:14]; d = ins[13:12]; s = ins[11:10];
    sv     = (s == 2'd3) ? 8'h00 : mr[s];
    svalid = (s == 2'd3) || mv[s];
    if (d != 2'd3) begin
      case (op)
        OP_MOV: begin mr[d] = sv; mv[d] = svalid; end
        OP_LDI: begin mr[d] = ins[7:0]; mv[d] = 1'b1; end
        OP_ALU: begin mr[d] = alu_f(ins[9:8], mr[d], sv); mv[d] = mv[d] && svalid; end
        default: begin mr[d] = 8'h00; mv[d] = 1'b1; end
      endcase
    end
  endtask

  task automatic check_regs();
    if (mv[0]) chk("reg_r0", {24'd0, rf0}, {24'd0, mr[0]});
    if (mv[1]) chk("reg_r1", {24'd0, rf1}, {24'd0, mr[1]});
    if (mv[2]) chk("reg_r2", {24'd0, rf2}, {24'd0, mr[2]});
  endtask

  task automatic wait_ready();
    for (int t = 0; t < 20 && bus.INSTR_READY !== 1'b1; t++) @(negedge CLK);
    chk("ready_before_issue", {31'd0, bus.INSTR_READY}, 32'd1);
  endtask

  // Issue one instruction and watch it through to the next IDLE cycle
  task automatic run_instr(input logic [15:0] ins);
    logic [1:0] op, d, s, fn;
    int         exp_lat, lat, lda, ldb;
    logic [1:0] a1, a2, mux_s;
    logic [2:0] sel_s;
    logic       err_s, busy_bad, sel_bad;
    op = ins[15:14]; d = ins[13:12]; s = ins[11:10]; fn = ins[9:8];
    exp_lat = (d == 2'd3 || op == OP_LDI) ? 1 : (op == OP_ALU) ? 4 : 2;
    lat = 0; lda = 0; ldb = 0; a1 = 0; a2 = 0; mux_s = 0; sel_s = 0; err_s = 0;
    busy_bad = 0; sel_bad = 0;
    wait_ready();
    bus.INSTR = ins;
    bus.INSTR_VALID = 1'b1;
    @(negedge CLK);
    bus.INSTR_VALID = 1'b0;
    bus.INSTR = 16'($urandom);
    for (int c = 1; c <= 8; c++) begin
      if (bus.BUSY !== 1'b1) busy_bad = 1;
      if (c == 1) a1 = bus.ADDR;
      if (c == 2) a2 = bus.ADDR;
      if (bus.LD_A === 1'b1) lda = c;
      if (bus.LD_B === 1'b1) ldb = c;
      if (bus.DONE === 1'b1 || bus.ERR === 1'b1) begin
        lat = c; sel_s = bus.SEL; mux_s = bus.IN_MUX; err_s = bus.ERR;
        break;
      end
      if (bus.SEL !== 3'b000) sel_bad = 1;
      @(negedge CLK);
    end
    chk("latency", lat, exp_lat);
    chk("busy_during", {31'd0, busy_bad}, 32'd0);
    chk("sel_early", {31'd0, sel_bad}, 32'd0);
    if (d == 2'd3) begin
      chk("err_pulse", {31'd0, err_s}, 32'd1);
      chk("err_sel", {29'd0, sel_s}, 32'd0);
    end else begin
      chk("wb_sel", {29'd0, sel_s}, 32'd1 << d);
      chk("wb_mux", {30'd0, mux_s}, (op == OP_LDI) ? 32'd1 : (op == OP_ALU) ? 32'd2 : 32'd0);
      chk("alu_fn", {30'd0, bus.ALU_FN}, {30'd0, fn});
      chk("imm_out", {24'd0, bus.IMM_OUT}, {24'd0, ins[7:0]});
      if (op == OP_ALU) begin
        chk("alu_addr1", {30'd0, a1}, {30'd0, d});
        chk("alu_addr2", {30'd0, a2}, {30'd0, s});
        chk("alu_lda", lda, 2);
        chk("alu_ldb", ldb, 3);
      end else if (op != OP_LDI) begin
        chk("rdb_addr", {30'd0, a1}, (op == OP_CLR) ? 32'd3 : {30'd0, s});
        chk("no_ld", lda + ldb, 0);
      end
    end
    @(negedge CLK);
    chk("ready_after", {31'd0, bus.INSTR_READY}, 32'd1);
    chk("done_low_idle", {31'd0, bus.DONE | bus.ERR}, 32'd0);
    model_apply(ins);
    check_regs();
  endtask

  logic [15:0] b2b [3];
  int          acc [3];
  int          dn [3];

  initial begin
    int idx, nd, endc;
    logic [15:0] instr_var;
    for (int i = 0; i < 3; i++) begin mr[i] = 8'h00; mv[i] = 1'b0; end
    bus.INSTR = 16'h0000;
    bus.INSTR_VALID = 1'b0;

    #12;
    chk("rst_ready", {31'd0, bus.INSTR_READY}, 32'd0);
    chk("rst_busy", {31'd0, bus.BUSY}, 32'd0);
    chk("rst_outs", {bus.SEL, bus.ADDR, bus.IN_MUX, bus.IMM_OUT, bus.ALU_FN,
                     bus.LD_A, bus.LD_B, bus.DONE, bus.ERR}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("ready_before_edge", {31'd0, bus.INSTR_READY}, 32'd0);
    @(negedge CLK);
    chk("ready_first_edge", {31'd0, bus.INSTR_READY}, 32'd1);

    run_instr(16'h40A5);
    run_instr(16'h403C);
    run_instr(16'h1000);
    run_instr(16'h6007);
    run_instr(16'hA500);
    run_instr(16'h7000);
    run_instr(16'hC000);

    // Reset while an ALU instruction sits in EX
    wait_ready();
    bus.INSTR = 16'hA500;
    bus.INSTR_VALID = 1'b1;
    @(negedge CLK);
    bus.INSTR_VALID = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("ex_ldb", {31'd0, bus.LD_B}, 32'd1);
    #2 RST = 1'b1;
    #1;
    chk("rst_mid_sel", {29'd0, bus.SEL}, 32'd0);
    chk("rst_mid_ldb", {31'd0, bus.LD_B}, 32'd0);
    chk("rst_mid_ready", {31'd0, bus.INSTR_READY}, 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    nd = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      if (bus.DONE === 1'b1 || bus.SEL !== 3'b000) nd++;
    end
    chk("rst_no_done", nd, 0);
    chk("rst_ready_back", {31'd0, bus.INSTR_READY}, 32'd1);
    check_regs();

    // Back-to-back with VALID held high
    b2b[0] = 16'h4055; b2b[1] = 16'h1000; b2b[2] = 16'hA500;
    wait_ready();
    idx = 0; nd = 0; endc = -1;
    for (int i = 0; i < 3; i++) begin acc[i] = -1; dn[i] = -1; end
    bus.INSTR_VALID = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (bus.DONE === 1'b1 && nd < 3) begin dn[nd] = c; nd++; end
      if (bus.INSTR_READY === 1'b1) begin
        if (idx == 3) begin
          endc = c;
          bus.INSTR_VALID = 1'b0;
          break;
        end
        acc[idx] = c;
        bus.INSTR = b2b[idx];
        idx++;
      end
      @(negedge CLK);
    end
    bus.INSTR_VALID = 1'b0;
    chk("b2b_acc0", acc[0], 0);
    chk("b2b_acc1", acc[1], 2);
    chk("b2b_acc2", acc[2], 5);
    chk("b2b_done0", dn[0], 1);
    chk("b2b_done1", dn[1], 4);
    chk("b2b_done2", dn[2], 9);
    chk("b2b_total", endc, 10);
    for (int i = 0; i < 3; i++) model_apply(b2b[i]);
    check_regs();

    for (int n = 0; n < 40; n++) begin
      instr_var = 16'($urandom);
      run_instr(instr_var);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
